// File: rtl/reg_file_sb_pkg.sv
// Shared defaults, architectural register names and protocol-error cause
// encoding for the scoreboarded register file.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NREAD  = 2;

  localparam int ZERO_REG = 0;
  // Return-address register by software convention; the hardware treats it like any other.
  localparam int LINK_REG = 31;

  typedef struct packed {
    logic dup_issue;
    logic spurious_ret;
    logic waw;
  } err_cause_t;

  function automatic logic any_err(input err_cause_t c);
    return c.dup_issue | c.spurious_ret | c.waw;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Pipeline-facing bundle of the register file: read ports, both write ports,
// load issue and scoreboard status.
interface reg_file_sb_if #(
  parameter int DATA_W = rf_pkg::RF_DATA_W,
  parameter int ADDR_W = rf_pkg::RF_ADDR_W,
  parameter int NREAD  = rf_pkg::RF_NREAD
);

  logic [NREAD*ADDR_W-1:0] ra;
  logic [NREAD*DATA_W-1:0] rd;
  logic [NREAD-1:0]        rd_busy;
  logic                    we;
  logic [ADDR_W-1:0]       wa;
  logic [DATA_W-1:0]       wd;
  logic                    lwe;
  logic [ADDR_W-1:0]       lwa;
  logic [DATA_W-1:0]       lwd;
  logic                    iss;
  logic [ADDR_W-1:0]       iss_a;
  logic [ADDR_W:0]         busy_cnt;
  logic                    err;

  modport master (
    output ra, we, wa, wd, lwe, lwa, lwd, iss, iss_a,
    input  rd, rd_busy, busy_cnt, err
  );

  modport slave (
    input  ra, we, wa, wd, lwe, lwa, lwd, iss, iss_a,
    output rd, rd_busy, busy_cnt, err
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Busy bits for outstanding loads, their population count and the sticky
// protocol-error flag.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NREGS  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_i,
  input  logic [ADDR_W-1:0] iss_a_i,
  input  logic              lwe_i,
  input  logic [ADDR_W-1:0] lwa_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  output logic [NREGS-1:0]  busy_o,
  output logic [ADDR_W:0]   busy_cnt_o,
  output logic              err_o
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
  err_cause_t       cause_s;

  function automatic logic [ADDR_W:0] popcount(input logic [NREGS-1:0] v);
    logic [ADDR_W:0] n;
    n = '0;
    for (int r = 0; r < NREGS; r++) begin
      n = n + (ADDR_W+1)'(v[r]);
    end
    return n;
  endfunction

  // Next busy vector, error causes and the count that goes with the new vector.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      // A new issue wins over a same-cycle return: the new load owns r.
      if (iss_i && iss_a_i == ADDR_W'(r)) begin
        busy_d[r] = 1'b1;
      end else if (lwe_i && lwa_i == ADDR_W'(r)) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
    busy_d[0] = 1'b0;

    cause_s.dup_issue    = iss_i && (iss_a_i != ZERO_A) && busy_q[iss_a_i]
                           && !(lwe_i && lwa_i == iss_a_i);
    cause_s.spurious_ret = lwe_i && (lwa_i != ZERO_A) && !busy_q[lwa_i];
    cause_s.waw          = we_i && (wa_i != ZERO_A) && busy_q[wa_i];

    err_d = err_q | any_err(cause_s);
    cnt_d = popcount(busy_d);
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;
  assign err_o      = err_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with ALU and load-return write ports, same-cycle bypass on
// every read port and a busy scoreboard for outstanding loads.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NREAD  = RF_NREAD
) (
  input  logic        clk,
  input  logic        rst_n,
  reg_file_sb_if.slave bus
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_s;
  logic [DATA_W-1:0] rd_s   [NREAD];
  logic [NREAD-1:0]  rd_busy_s;

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .iss_i      (bus.iss),
    .iss_a_i    (bus.iss_a),
    .lwe_i      (bus.lwe),
    .lwa_i      (bus.lwa),
    .we_i       (bus.we),
    .wa_i       (bus.wa),
    .busy_o     (busy_s),
    .busy_cnt_o (bus.busy_cnt),
    .err_o      (bus.err)
  );

  // Storage next state; the ALU write is younger and overrides a load return.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      if (r == ZERO_REG) begin
        regs_d[r] = '0;
      end else if (bus.we && bus.wa == ADDR_W'(r)) begin
        regs_d[r] = bus.wd;
      end else if (bus.lwe && bus.lwa == ADDR_W'(r)) begin
        regs_d[r] = bus.lwd;
      end else begin
        regs_d[r] = regs_q[r];
      end
    end
  end

  // Register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    logic              lhit_s;
    assign ra_s   = bus.ra[p*ADDR_W +: ADDR_W];
    assign lhit_s = bus.lwe && (bus.lwa == ra_s);

    // Bypass mux: ALU write, then load return, then storage.
    always_comb begin
      if (ra_s == ZERO_A) begin
        rd_s[p]      = '0;
        rd_busy_s[p] = 1'b0;
      end else if (bus.we && bus.wa == ra_s) begin
        rd_s[p]      = bus.wd;
        rd_busy_s[p] = busy_s[ra_s] && !lhit_s;
      end else if (lhit_s) begin
        rd_s[p]      = bus.lwd;
        rd_busy_s[p] = 1'b0;
      end else begin
        rd_s[p]      = regs_q[ra_s];
        rd_busy_s[p] = busy_s[ra_s];
      end
    end
  end

  // Pack per-port results onto the bus.
  always_comb begin
    bus.rd = '0;
    for (int p = 0; p < NREAD; p++) begin
      bus.rd[p*DATA_W +: DATA_W] = rd_s[p];
    end
  end

  assign bus.rd_busy = rd_busy_s;

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with configurable width, depth and read-port count, two write ports (ALU writeback and late load return), same-cycle write-to-read bypass and a per-register busy scoreboard for outstanding loads. It replaces the two-read/one-write register file in the datapath. It lets the pipeline issue a load, keep running, and stall only on a read of a register whose data has not yet returned.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W
- NREAD, 2, number of read ports
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- ra  input  NREAD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rd  output  NREAD*DATA_W  read data, combinational
- rd_busy  output  NREAD  1 when the read register awaits a load return
- we, wa, wd  input  1/ADDR_W/DATA_W  ALU writeback port
- lwe, lwa, lwd  input  1/ADDR_W/DATA_W  load-return write port
- iss, iss_a  input  1/ADDR_W  load issue; marks iss_a busy
- busy_cnt  output  ADDR_W+1  number of busy registers
- err  output  1  sticky protocol-error flag

## Operation
- Reset: one clock and one reset domain. Reset is asynchronous and active-low, and is not released before the clock runs.
- Reset values: all registers are 0, all busy bits are 0, busy_cnt is 0 and err is 0. The same values apply immediately on rst_n low, including when a reset arrives mid-operation.
- Register 0:
  - always reads 0;
  - writes to it from either port are dropped;
  - an issue to it is ignored and does not set busy.
- Writes happen on the rising edge of clk:
  - we=1 writes wd to wa;
  - lwe=1 writes lwd to lwa;
  - if both target the same nonzero address, the ALU write wins, because it is younger in program order.
- Read port i, priority order:
  1. ra_i=0 gives 0;
  2. else we && wa==ra_i gives wd;
  3. else lwe && lwa==ra_i gives lwd;
  4. else the stored value.
- rd_busy_i = busy[ra_i] && !(lwe && lwa==ra_i). A return in the current cycle clears the stall combinationally. rd_busy_i is always 0 for address 0.
- Scoreboard, evaluated each clock edge for each nonzero address r:
  - set when iss && iss_a==r;
  - clear when lwe && lwa==r;
  - if set and clear hit the same r in one cycle, the result is busy=1 (the new load owns r).
- An issue becomes visible in rd_busy from the next cycle.
- busy_cnt equals the population count of the busy bits after each edge. It is registered and updated in the same edge as the busy bits. Its maximum is NREGS-1.
- err is set on any of the following, and stays set until reset:
  - iss to an r that is already busy and not being cleared this cycle (a second outstanding load);
  - lwe to an r that is not busy (a spurious return);
  - we to an r that is busy (a WAW hazard against a pending load).
- The offending write or issue is still performed. For the spurious-return case the busy bit is unchanged.

## Timing
- Read path latency is 0 cycles, combinational from ra, wa/wd and lwa/lwd.
- Write to storage takes 1 cycle; the bypass hides this latency.
- busy, busy_cnt and err take effect 1 cycle after the triggering edge.
- No handshake backpressure: the ports always accept. The pipeline stalls on rd_busy.

## Structure
- Package rf_pkg holds:
  - the default DATA_W, ADDR_W and NREAD;
  - ZERO_REG = 0;
  - LINK_REG = 31, documented as the return-address register; no special hardware.
- Sub-module rf_scoreboard holds the NREGS busy bits, the busy_cnt register and the err logic, with inputs iss/iss_a/lwe/lwa/we/wa.
- The top level holds the storage array, write priority and the NREAD bypass read muxes, generated per port.

## Test plan
- Reset and zero register: hold rst_n low then release, write 0x1234 to r0, then read r0 -> 0; all other registers read 0, busy_cnt=0, err=0.
- Bypass and write priority:
  - we, wa=5, wd=0xA5 in the same cycle as ra0=5 -> rd0=0xA5 in that cycle;
  - next cycle, we to r7=1 and lwe to r7=2 together, then read r7 -> 1.
- Load scoreboard:
  - iss r3, then next cycle ra1=3 -> rd_busy1=1 and busy_cnt=1;
  - lwe r3=0xDEAD -> rd_busy1=0 and rd1=0xDEAD in the same cycle; busy_cnt=0 on the next cycle.
- Simultaneous issue and return: r4 busy, then lwe r4 and iss r4 in the same cycle -> r4 stays busy, err=0, busy_cnt unchanged.
- Protocol errors and reset: iss r6 twice -> err=1 and it stays 1. Then assert rst_n mid-sequence with r6 busy -> immediately busy_cnt=0, err=0, rd of r6=0.
- Parametrisation: DATA_W=16, ADDR_W=3, NREAD=3 -> repeat the bypass and scoreboard tests on all three ports; an issue to each of r1..r7 -> busy_cnt=7.
